// File: rtl/esp_square_tx.sv
`default_nettype none
// ============================================================================
//  Module      : esp_square_tx
//  Description : UART 8N1 transmitter toward the ESP. Each generated target
//                square (latched on salvaNova) is sent as one byte
//                {2'b01, coluna, linha}; enviaFim sends an end-of-game marker
//                byte. Requests land in small holding registers first so they
//                are never lost while a frame is on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module esp_square_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  FIM_BYTE     = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] linhaGerada,
  input  logic [2:0] colunaGerada,
  input  logic       salvaNova,
  input  logic       enviaFim,
  output logic       tx,
  output logic       ocupado,
  output logic       sobrescrito,
  output logic [3:0] db_estado
);

  // Baud counter runs 0..CLKS_PER_BIT-1; keep at least one bit of width.
  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // FSM encoding doubles as the hex-display code.
  localparam logic [1:0] S_OCIOSO = 2'd0;
  localparam logic [1:0] S_INICIO = 2'd1;
  localparam logic [1:0] S_DADOS  = 2'd2;
  localparam logic [1:0] S_PARADA = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;

  // Holding registers: one-entry square buffer and the end-of-game flag.
  logic             pend_q_valid;
  logic [7:0]       pend_q_byte;
  logic             pend_f;

  // Serializer datapath.
  logic [7:0]       frame_data;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             tx_next;

  logic             bit_done;
  logic             load_sq;
  logic             load_fim;
  logic [7:0]       square_byte;

  // The top two bits 01 keep a square byte distinct from the marker byte.
  assign square_byte = {2'b01, colunaGerada, linhaGerada};

  // End of the current bit period.
  assign bit_done = (baud_cnt == BAUD_LAST);

  // Loading happens only from idle; a pending square wins over the marker.
  assign load_sq  = (state == S_OCIOSO) && pend_q_valid;
  assign load_fim = (state == S_OCIOSO) && !pend_q_valid && pend_f;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_OCIOSO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    state_next = state;
    case (state)
      S_OCIOSO: begin
        if (pend_q_valid || pend_f) begin
          state_next = S_INICIO;
        end
      end
      S_INICIO: begin
        if (bit_done) begin
          state_next = S_DADOS;
        end
      end
      S_DADOS: begin
        if (bit_done && (bit_idx == 3'd7)) begin
          state_next = S_PARADA;
        end
      end
      S_PARADA: begin
        if (bit_done) begin
          state_next = S_OCIOSO;
        end
      end
      default: state_next = S_OCIOSO;
    endcase
  end

  // FSM outputs: line level for the next cycle, busy flag and display code.
  always_comb begin
    tx_next   = 1'b1;
    ocupado   = (state != S_OCIOSO) || pend_q_valid || pend_f;
    db_estado = {2'b00, state};
    case (state)
      S_OCIOSO: tx_next = 1'b1;
      S_INICIO: tx_next = 1'b0;
      S_DADOS:  tx_next = frame_data[bit_idx];
      S_PARADA: tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
  end

  // Request capture. A request always lands in the holding registers; when a
  // square is loaded on the same edge a new one arrives, the new one is kept
  // and nothing counts as overwritten.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_q_valid <= 1'b0;
      pend_q_byte  <= 8'h00;
      pend_f       <= 1'b0;
      sobrescrito  <= 1'b0;
    end else begin
      if (salvaNova) begin
        pend_q_valid <= 1'b1;
        pend_q_byte  <= square_byte;
        if (pend_q_valid && !load_sq) begin
          sobrescrito <= 1'b1;
        end
      end else if (load_sq) begin
        pend_q_valid <= 1'b0;
      end

      if (enviaFim) begin
        pend_f <= 1'b1;
      end else if (load_fim) begin
        pend_f <= 1'b0;
      end
    end
  end

  // Baud timing, bit index and frame byte; all held at zero while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      frame_data <= 8'h00;
    end else if (state == S_OCIOSO) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      if (load_sq) begin
        frame_data <= pend_q_byte;
      end else if (load_fim) begin
        frame_data <= FIM_BYTE;
      end
    end else begin
      baud_cnt <= bit_done ? '0 : (baud_cnt + CNT_W'(1));
      if ((state == S_DADOS) && bit_done) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Registered line driver so the pin never glitches; reset forces idle-high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esp_square_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esp_square_tx
//  Description : Self-checking bench for esp_square_tx with CLKS_PER_BIT=4.
//                A line monitor decodes UART frames from tx; a cycle-level
//                reference model of the request buffering predicts frames,
//                busy and overwrite flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esp_square_tx;

  localparam int         CPB   = 4;
  localparam int         FRAME = 10 * CPB;
  localparam logic [7:0] FIM   = 8'hFF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] linhaGerada = 3'd0;
  logic [2:0] colunaGerada = 3'd0;
  logic       salvaNova = 1'b0;
  logic       enviaFim = 1'b0;
  logic       tx;
  logic       ocupado;
  logic       sobrescrito;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  esp_square_tx #(
    .CLKS_PER_BIT(CPB),
    .FIM_BYTE    (FIM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .linhaGerada (linhaGerada),
    .colunaGerada(colunaGerada),
    .salvaNova   (salvaNova),
    .enviaFim    (enviaFim),
    .tx          (tx),
    .ocupado     (ocupado),
    .sobrescrito (sobrescrito),
    .db_estado   (db_estado)
  );

  function automatic logic [7:0] sq(input logic [2:0] l, input logic [2:0] c);
    return {2'b01, c, l};
  endfunction

  // Reference model: a transmitter that is busy for one frame length after
  // it takes a pending item, one square slot, one marker flag, sticky flag.
  int         m_busy = 0;
  bit         m_pq = 0;
  bit         m_pf = 0;
  bit         m_sticky = 0;
  logic [7:0] m_qb = 8'h00;
  logic [7:0] m_cur = 8'h00;

  always @(posedge clock) begin
    if (!reset) begin
      m_busy = 0; m_pq = 0; m_pf = 0; m_sticky = 0;
    end else begin
      if (m_busy == 0) begin
        if (m_pq) begin
          m_cur = m_qb; m_pq = 0; m_busy = FRAME;
        end else if (m_pf) begin
          m_cur = FIM; m_pf = 0; m_busy = FRAME;
        end
      end else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) exp_q.push_back(m_cur);
      end
      if (salvaNova) begin
        if (m_pq) m_sticky = 1;
        m_pq = 1;
        m_qb = sq(linhaGerada, colunaGerada);
      end
      if (enviaFim) m_pf = 1;
    end
  end

  // Line monitor: collects FRAME samples from the first low level, checks
  // framing (start low, steady data bits, stop high) and records the byte.
  logic smp[FRAME];
  int   mon_idx = 0;
  bit   mon_active = 0;
  int   mon_gap = 0;
  int   last_gap = 0;

  always @(negedge clock) begin
    bit         fr_ok;
    logic [7:0] fr_b;
    if (reset !== 1'b1) begin
      mon_active = 0;
      mon_gap    = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1; smp[0] = 1'b0; mon_idx = 1; last_gap = mon_gap;
      end else begin
        mon_gap++;
      end
    end else begin
      smp[mon_idx] = tx;
      mon_idx++;
      if (mon_idx == FRAME) begin
        fr_ok = 1;
        fr_b  = 8'h00;
        for (int j = 0; j < CPB; j++) begin
          if (smp[j] !== 1'b0) fr_ok = 0;
          if (smp[9*CPB + j] !== 1'b1) fr_ok = 0;
        end
        for (int i = 0; i < 8; i++) begin
          fr_b[i] = smp[CPB + CPB*i];
          for (int j = 1; j < CPB; j++)
            if (smp[CPB + CPB*i + j] !== smp[CPB + CPB*i]) fr_ok = 0;
        end
        tests++;
        if (!fr_ok) begin
          fails++;
          $display("FAIL framing: malformed frame on tx, got bits %h, required clean 8N1 frame", fr_b);
        end else begin
          got_q.push_back(fr_b);
        end
        mon_active = 0;
        mon_gap    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_sq(input logic [2:0] l, input logic [2:0] c);
    linhaGerada = l; colunaGerada = c; salvaNova = 1'b1;
    tick();
    salvaNova = 1'b0;
  endtask

  task automatic pulse_fim();
    enviaFim = 1'b1;
    tick();
    enviaFim = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (db_estado == st) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ocupado === 1'b0 && m_busy == 0) begin ok = 1; break; end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; salvaNova = 1'b1; linhaGerada = 3'd5; colunaGerada = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b required 1", tx); end
      tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado: got %b required 0", ocupado); end
      tests++; if (sobrescrito !== 1'b0) begin fails++; $display("FAIL reset_sobrescrito: got %b required 0", sobrescrito); end
      tests++; if (db_estado !== 4'd0) begin fails++; $display("FAIL reset_estado: got %0d required 0", db_estado); end
    end
    salvaNova = 1'b0; reset = 1'b1;
    tick(); tick();
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_release_idle: got %b required 0", ocupado); end
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    pulse_sq(3'b101, 3'b010);                 // captured at edge N
    tick();                                   // edge N+1: loaded, line still idle
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_latency_n1: got tx %b required 1", tx); end
    tests++; if (db_estado !== 4'd1) begin fails++; $display("FAIL single_inicio: got %0d required 1", db_estado); end
    tick();                                   // edge N+2: start bit on the line
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL single_latency_n2: got tx %b required 0", tx); end
    repeat (38) tick();                       // edge N+40: stop bit still running
    tests++; if (ocupado !== 1'b1) begin fails++; $display("FAIL single_busy_end: got %b required 1", ocupado); end
    tick();                                   // edge N+41: back to idle
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL single_idle_after: got %b required 0", ocupado); end
    tests++; if (db_estado !== 4'd0) begin fails++; $display("FAIL single_estado_after: got %0d required 0", db_estado); end
    tick(); tick();
    tests++;
    if (got_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d frames required 1", got_q.size()); end
    else if (got_q[0] !== 8'h55) begin fails++; $display("FAIL single_byte: got %h required 55", got_q[0]); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    got_q.delete(); exp_q.delete();
    linhaGerada = 3'd0; colunaGerada = 3'd0; salvaNova = 1'b1; enviaFim = 1'b1;
    tick();
    salvaNova = 1'b0; enviaFim = 1'b0;
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL simul_timeout: got busy required idle"); end
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL simul_count: got %0d frames required 2", got_q.size()); end
    else begin
      if (got_q[0] !== 8'h40) begin fails++; $display("FAIL simul_first: got %h required 40", got_q[0]); end
      tests++;
      if (got_q[1] !== 8'hFF) begin fails++; $display("FAIL simul_second: got %h required ff", got_q[1]); end
      tests++;
      if (last_gap < 1) begin fails++; $display("FAIL simul_gap: got %0d idle cycles required >=1", last_gap); end
    end
  endtask

  task automatic test_fim_idempotent();
    bit ok;
    logic [2:0] l, c;
    got_q.delete(); exp_q.delete();
    l = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
    pulse_sq(l, c);
    wait_state(4'd2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL fim_wait_dados: got estado %0d required 2", db_estado); end
    pulse_fim(); tick(); tick();
    pulse_fim(); repeat (5) tick();
    pulse_fim();
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL fim_timeout: got busy required idle"); end
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL fim_count: got %0d frames required 2", got_q.size()); end
    else begin
      if (got_q[0] !== sq(l, c)) begin fails++; $display("FAIL fim_square: got %h required %h", got_q[0], sq(l, c)); end
      tests++;
      if (got_q[1] !== 8'hFF) begin fails++; $display("FAIL fim_marker: got %h required ff", got_q[1]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      linhaGerada  = 3'($urandom_range(0, 7));
      colunaGerada = 3'($urandom_range(0, 7));
      salvaNova    = ($urandom_range(0, 9) == 0);
      enviaFim     = ($urandom_range(0, 19) == 0);
      tick();
      tests++;
      if (ocupado !== (m_busy > 0 || m_pq || m_pf)) begin
        fails++; $display("FAIL rand_ocupado cycle %0d: got %b required %b", i, ocupado, (m_busy > 0 || m_pq || m_pf));
      end
      tests++;
      if (sobrescrito !== m_sticky) begin
        fails++; $display("FAIL rand_sobrescrito cycle %0d: got %b required %b", i, sobrescrito, m_sticky);
      end
    end
    salvaNova = 1'b0; enviaFim = 1'b0;
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rand_timeout: got busy required idle"); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_count: got %0d frames required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_frame %0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overwrite();
    bit ok;
    logic [5:0] v;
    logic [7:0] a, b, c;
    got_q.delete(); exp_q.delete();
    v = 6'($urandom_range(0, 63));
    a = sq(v[2:0], v[5:3]);
    b = sq(v[2:0] ^ 3'd1, v[5:3]);
    c = sq(v[2:0] ^ 3'd2, v[5:3]);
    pulse_sq(a[2:0], a[5:3]);
    wait_state(4'd2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovw_wait_dados: got estado %0d required 2", db_estado); end
    pulse_sq(b[2:0], b[5:3]);
    repeat (3) tick();
    pulse_sq(c[2:0], c[5:3]);
    tests++; if (sobrescrito !== 1'b1) begin fails++; $display("FAIL ovw_sticky: got %b required 1", sobrescrito); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovw_timeout: got busy required idle"); end
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL ovw_count: got %0d frames required 2", got_q.size()); end
    else begin
      if (got_q[0] !== a) begin fails++; $display("FAIL ovw_first: got %h required %h", got_q[0], a); end
      tests++;
      if (got_q[1] !== c) begin fails++; $display("FAIL ovw_second: got %h required %h", got_q[1], c); end
    end
    tests++; if (sobrescrito !== 1'b1) begin fails++; $display("FAIL ovw_sticky_hold: got %b required 1", sobrescrito); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int bad;
    got_q.delete(); exp_q.delete();
    pulse_sq(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    wait_state(4'd2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_wait_dados: got estado %0d required 2", db_estado); end
    repeat (3 * CPB) tick();                  // now inside data bit 3
    reset = 1'b0;
    tick();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b required 1", tx); end
    tests++; if (db_estado !== 4'd0) begin fails++; $display("FAIL rstmid_estado: got %0d required 0", db_estado); end
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL rstmid_ocupado: got %b required 0", ocupado); end
    tests++; if (sobrescrito !== 1'b0) begin fails++; $display("FAIL rstmid_sobrescrito: got %b required 0", sobrescrito); end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || ocupado !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_no_restart: got %0d active cycles required 0", bad); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rstmid_frames: got %0d frames required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fim_idempotent();
    test_random();
    test_overwrite();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
